// File: rtl/axi_rd_arb_pkg.sv
// Shared types and constants for the two-master AXI read arbiter.
// Contents: FSM state enum, master index constants, AXI burst encodings,
// fixed AXI field widths.
package axi_rd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    localparam logic M_IFU = 1'b0;
    localparam logic M_LSU = 1'b1;

    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;

    localparam int unsigned LEN_W   = 8;
    localparam int unsigned SIZE_W  = 3;
    localparam int unsigned BURST_W = 2;
    localparam int unsigned RESP_W  = 2;

endpackage

// File: rtl/axi_rd_if.sv
// AXI-full read channel (AR + R) bundle.
// master modport: drives AR request and R ready.
// slave modport : drives AR ready and the R beat.
interface axi_rd_if
    import axi_rd_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 4
);
    logic                arvalid;
    logic                arready;
    logic [ADDR_W-1:0]   araddr;
    logic [ID_W-1:0]     arid;
    logic [LEN_W-1:0]    arlen;
    logic [SIZE_W-1:0]   arsize;
    logic [BURST_W-1:0]  arburst;
    logic                rvalid;
    logic                rready;
    logic [DATA_W-1:0]   rdata;
    logic [RESP_W-1:0]   rresp;
    logic                rlast;
    logic [ID_W-1:0]     rid;

    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst, rready,
        input  arready, rvalid, rdata, rresp, rlast, rid
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
        output arready, rvalid, rdata, rresp, rlast, rid
    );
endinterface

// File: rtl/axi_rd_arb_grant.sv
// Two-way grant selection plus the owner register.
// Build option: AXI_RD_ARB_ROUND_ROBIN_EN -> ties go to the master that
// was not the last owner; otherwise the LSU (m1) always wins ties.
// Ports: i_clock, i_reset (async active-low), i_req0/i_req1 requests,
//        i_update (grant taken this cycle), o_any, o_winner, o_owner.
module axi_rd_arb_grant
    import axi_rd_arb_pkg::*;
(
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_update,
    output logic o_any,
    output logic o_winner,
    output logic o_owner
);
    logic r_owner;
    logic w_winner;

    // Winner selection; single requester always wins regardless of build.
    always_comb begin
        w_winner = M_IFU;
        if (i_req0 && i_req1) begin
`ifdef AXI_RD_ARB_ROUND_ROBIN_EN
            w_winner = ~r_owner;
`else
            w_winner = M_LSU;
`endif
        end else if (i_req1) begin
            w_winner = M_LSU;
        end
    end

    // Owner is held after the transaction ends; it seeds round-robin ties.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_owner <= M_IFU;
        end else if (i_update) begin
            r_owner <= w_winner;
        end
    end

    assign o_any    = i_req0 | i_req1;
    assign o_winner = w_winner;
    assign o_owner  = r_owner;

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-master (IFU=m0, LSU=m1) to one-slave AXI read arbiter.
// One outstanding read; the owner is locked from AR grant to the last R beat.
// Build option: AXI_RD_ARB_ROUND_ROBIN_EN (round-robin tie break).
// Ports: i_clock, i_reset (async active-low); io_m0/io_m1 master-side
//        buses; io_s slave-side bus; o_owner current/last owner;
//        o_busy (state != IDLE); o_proto_err sticky burst-length error.
module axi_rd_arbiter
    import axi_rd_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 4
) (
    input  logic       i_clock,
    input  logic       i_reset,
    axi_rd_if.slave    io_m0,
    axi_rd_if.slave    io_m1,
    axi_rd_if.master   io_s,
    output logic       o_owner,
    output logic       o_busy,
    output logic       o_proto_err
);
    state_e               r_state;
    logic [ADDR_W-1:0]    r_araddr;
    logic [ID_W-1:0]      r_arid;
    logic [LEN_W-1:0]     r_arlen;
    logic [SIZE_W-1:0]    r_arsize;
    logic [BURST_W-1:0]   r_arburst;
    logic [LEN_W-1:0]     r_beat;
    logic                 r_proto_err;

    logic w_any, w_win, w_owner, w_grant;
    logic w_in_data, w_to_m0, w_to_m1, w_r_hs;

    axi_rd_arb_grant u_grant (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_req0   (io_m0.arvalid),
        .i_req1   (io_m1.arvalid),
        .i_update (w_grant),
        .o_any    (w_any),
        .o_winner (w_win),
        .o_owner  (w_owner)
    );

    // Reset gates the combinational handshakes so nothing is accepted while held.
    assign w_grant   = i_reset & (r_state == IDLE) & w_any;
    assign w_in_data = (r_state == DATA);
    assign w_to_m0   = w_in_data & (w_owner == M_IFU);
    assign w_to_m1   = w_in_data & (w_owner == M_LSU);
    assign w_r_hs    = io_s.rvalid & io_s.rready;

    // AR grant pulses in the IDLE cycle only.
    assign io_m0.arready = w_grant & (w_win == M_IFU);
    assign io_m1.arready = w_grant & (w_win == M_LSU);

    // Slave AR from the latch.
    assign io_s.arvalid = (r_state == ADDR);
    assign io_s.araddr  = r_araddr;
    assign io_s.arid    = r_arid;
    assign io_s.arlen   = r_arlen;
    assign io_s.arsize  = r_arsize;
    assign io_s.arburst = r_arburst;

    // R routing; outside DATA any stray beat is drained.
    assign io_s.rready = w_in_data ? ((w_owner == M_LSU) ? io_m1.rready : io_m0.rready)
                                   : i_reset;

    assign io_m0.rvalid = w_to_m0 & io_s.rvalid;
    assign io_m0.rdata  = w_to_m0 ? io_s.rdata : '0;
    assign io_m0.rresp  = w_to_m0 ? io_s.rresp : '0;
    assign io_m0.rlast  = w_to_m0 & io_s.rlast;
    assign io_m0.rid    = w_to_m0 ? io_s.rid   : '0;

    assign io_m1.rvalid = w_to_m1 & io_s.rvalid;
    assign io_m1.rdata  = w_to_m1 ? io_s.rdata : '0;
    assign io_m1.rresp  = w_to_m1 ? io_s.rresp : '0;
    assign io_m1.rlast  = w_to_m1 & io_s.rlast;
    assign io_m1.rid    = w_to_m1 ? io_s.rid   : '0;

    // FSM, AR latch, beat counter and sticky protocol error.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= IDLE;
            r_araddr    <= '0;
            r_arid      <= '0;
            r_arlen     <= '0;
            r_arsize    <= '0;
            r_arburst   <= '0;
            r_beat      <= '0;
            r_proto_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_state   <= ADDR;
                        r_beat    <= '0;
                        r_araddr  <= w_win ? io_m1.araddr  : io_m0.araddr;
                        r_arid    <= w_win ? io_m1.arid    : io_m0.arid;
                        r_arlen   <= w_win ? io_m1.arlen   : io_m0.arlen;
                        r_arsize  <= w_win ? io_m1.arsize  : io_m0.arsize;
                        r_arburst <= w_win ? io_m1.arburst : io_m0.arburst;
                    end
                end
                ADDR: begin
                    if (io_s.arready) begin
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_r_hs) begin
                        // Counts beats already delivered; last beat index must equal arlen.
                        r_beat <= r_beat + LEN_W'(1);
                        if (io_s.rlast) begin
                            r_state <= IDLE;
                            if (r_beat != r_arlen) begin
                                r_proto_err <= 1'b1;
                            end
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
            if (w_r_hs && !w_in_data) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign o_owner     = w_owner;
    assign o_busy      = (r_state != IDLE);
    assign o_proto_err = r_proto_err;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: stimulus pushes expected grants,
// slave AR requests and R beats; a monitor pops and compares them.
module tb_axi_rd_arbiter;
    import axi_rd_arb_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  id;
        logic [7:0]  len;
        logic [1:0]  burst;
    } ar_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [3:0]  id;
    } r_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  id;
        int          n;
    } burst_t;

    logic clk;
    logic i_reset;
    logic o_owner, o_busy, o_proto_err;

    axi_rd_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) m0_if ();
    axi_rd_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) m1_if ();
    axi_rd_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) s_if ();

    axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
        .i_clock     (clk),
        .i_reset     (i_reset),
        .io_m0       (m0_if),
        .io_m1       (m1_if),
        .io_s        (s_if),
        .o_owner     (o_owner),
        .o_busy      (o_busy),
        .o_proto_err (o_proto_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    bit     q_g[$];
    ar_t    q_ar[$];
    r_t     q_r0[$];
    r_t     q_r1[$];
    burst_t sq[$];
    int     slv_beat = 0;
    int     slv_ovr  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic req(input bit m, input logic [31:0] a, input logic [3:0] id,
                       input logic [7:0] len, input logic [1:0] b);
        if (m) begin
            m1_if.araddr = a; m1_if.arid = id; m1_if.arlen = len;
            m1_if.arsize = 3'd2; m1_if.arburst = b; m1_if.arvalid = 1'b1;
        end else begin
            m0_if.araddr = a; m0_if.arid = id; m0_if.arlen = len;
            m0_if.arsize = 3'd2; m0_if.arburst = b; m0_if.arvalid = 1'b1;
        end
    endtask

    task automatic exp_ar(input logic [31:0] a, input logic [3:0] id,
                          input logic [7:0] len, input logic [1:0] b);
        ar_t e;
        e.addr = a; e.id = id; e.len = len; e.burst = b;
        q_ar.push_back(e);
    endtask

    task automatic exp_r(input bit m, input logic [31:0] d, input logic last, input logic [3:0] id);
        r_t e;
        e.data = d; e.last = last; e.id = id;
        if (m) q_r1.push_back(e);
        else   q_r0.push_back(e);
    endtask

    // Waits (bounded) until all traffic has finished, then aligns to drive time.
    task automatic wait_quiet(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!(!m0_if.arvalid && !m1_if.arvalid && !o_busy && sq.size() == 0 && !s_if.rvalid)
               && n < 60) begin
            n++;
            @(negedge clk);
        end
        check({"quiet_", tag}, 64'(n < 60), 64'd1);
        @(posedge clk); #1;
    endtask

    // Monitor: compare every presented handshake against the scoreboard.
    initial begin
        bit  g;
        ar_t ea;
        r_t  er;
        forever begin
            @(negedge clk);
            if (i_reset) begin
                if (m0_if.arready || m1_if.arready) begin
                    check("grant_onehot", 64'(m0_if.arready & m1_if.arready), 64'd0);
                    if (q_g.size() == 0) check("grant_unexpected", 64'd1, 64'd0);
                    else begin
                        g = q_g.pop_front();
                        check("grant_winner", 64'(m1_if.arready), 64'(g));
                    end
                end
                if (s_if.arvalid && s_if.arready) begin
                    if (q_ar.size() == 0) check("s_ar_unexpected", 64'd1, 64'd0);
                    else begin
                        ea = q_ar.pop_front();
                        check("s_ar", 64'({s_if.araddr, s_if.arid, s_if.arlen, s_if.arsize, s_if.arburst}),
                              64'({ea.addr, ea.id, ea.len, 3'd2, ea.burst}));
                    end
                end
                if (m0_if.rvalid && m1_if.rvalid) check("r_both_valid", 64'd1, 64'd0);
                if (m0_if.rvalid && m0_if.rready) begin
                    if (q_r0.size() == 0) check("m0_r_unexpected", 64'd1, 64'd0);
                    else begin
                        er = q_r0.pop_front();
                        check("m0_r", 64'({m0_if.rdata, m0_if.rlast, m0_if.rid, m0_if.rresp}),
                              64'({er.data, er.last, er.id, 2'b00}));
                    end
                end
                if (m1_if.rvalid && m1_if.rready) begin
                    if (q_r1.size() == 0) check("m1_r_unexpected", 64'd1, 64'd0);
                    else begin
                        er = q_r1.pop_front();
                        check("m1_r", 64'({m1_if.rdata, m1_if.rlast, m1_if.rid, m1_if.rresp}),
                              64'({er.data, er.last, er.id, 2'b00}));
                    end
                end
            end
        end
    end

    // Master AR drop after handshake + behavioural slave (data = addr + beat).
    initial begin
        bit h0, h1, sar, sr;
        burst_t b;
        forever begin
            @(negedge clk);
            h0  = m0_if.arvalid & m0_if.arready;
            h1  = m1_if.arvalid & m1_if.arready;
            sar = s_if.arvalid & s_if.arready;
            sr  = s_if.rvalid & s_if.rready;
            b.addr = s_if.araddr;
            b.id   = s_if.arid;
            b.n    = (slv_ovr != 0) ? slv_ovr : int'(s_if.arlen) + 1;
            @(posedge clk); #1;
            if (h0) m0_if.arvalid = 1'b0;
            if (h1) m1_if.arvalid = 1'b0;
            if (sr && sq.size() > 0) begin
                slv_beat++;
                if (slv_beat == sq[0].n) begin
                    void'(sq.pop_front());
                    slv_beat = 0;
                end
            end
            if (sar) sq.push_back(b);
            if (sq.size() > 0) begin
                s_if.rvalid = 1'b1;
                s_if.rdata  = sq[0].addr + 32'(slv_beat);
                s_if.rid    = sq[0].id;
                s_if.rlast  = (slv_beat == sq[0].n - 1);
            end else begin
                s_if.rvalid = 1'b0;
                s_if.rdata  = '0;
                s_if.rid    = '0;
                s_if.rlast  = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        i_reset = 1'b0;
        m0_if.arvalid = 0; m0_if.araddr = 0; m0_if.arid = 0; m0_if.arlen = 0;
        m0_if.arsize = 0; m0_if.arburst = 0; m0_if.rready = 1'b1;
        m1_if.arvalid = 0; m1_if.araddr = 0; m1_if.arid = 0; m1_if.arlen = 0;
        m1_if.arsize = 0; m1_if.arburst = 0; m1_if.rready = 1'b1;
        s_if.arready = 1'b1; s_if.rvalid = 0; s_if.rdata = 0; s_if.rresp = 0;
        s_if.rlast = 0; s_if.rid = 0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy",    64'(o_busy), 64'd0);
        check("rst_owner",   64'(o_owner), 64'd0);
        check("rst_perr",    64'(o_proto_err), 64'd0);
        check("rst_s_arv",   64'(s_if.arvalid), 64'd0);
        check("rst_s_rrdy",  64'(s_if.rready), 64'd0);
        @(posedge clk); #1;
        i_reset = 1'b1;
        @(posedge clk); #1;

        // T1: single IFU WRAP read with slave AR stall
        q_g.push_back(1'b0);
        exp_ar(32'h8000_0004, 4'd3, 8'd1, WRAP);
        exp_r(1'b0, 32'h8000_0004, 1'b0, 4'd3);
        exp_r(1'b0, 32'h8000_0005, 1'b1, 4'd3);
        req(1'b0, 32'h8000_0004, 4'd3, 8'd1, WRAP);
        s_if.arready = 1'b0;
        @(negedge clk);
        check("t1_arready", 64'(m0_if.arready), 64'd1);
        check("t1_s_arv0",  64'(s_if.arvalid), 64'd0);
        @(negedge clk);
        check("t1_s_ar", 64'({s_if.arvalid, s_if.araddr}), 64'({1'b1, 32'h8000_0004}));
        check("t1_arready_once", 64'(m0_if.arready), 64'd0);
        @(negedge clk);
        check("t1_s_ar_hold", 64'({s_if.arvalid, s_if.araddr}), 64'({1'b1, 32'h8000_0004}));
        @(posedge clk); #1;
        s_if.arready = 1'b1;
        wait_quiet("t1");
        check("t1_perr",  64'(o_proto_err), 64'd0);
        check("t1_owner", 64'(o_owner), 64'd0);

        // T2: tie after m0 -> m1 first in both builds
        q_g.push_back(1'b1); q_g.push_back(1'b0);
        exp_ar(32'h0F00_0010, 4'd2, 8'd0, INCR);
        exp_ar(32'h1000_0020, 4'd1, 8'd0, INCR);
        exp_r(1'b1, 32'h0F00_0010, 1'b1, 4'd2);
        exp_r(1'b0, 32'h1000_0020, 1'b1, 4'd1);
        req(1'b0, 32'h1000_0020, 4'd1, 8'd0, INCR);
        req(1'b1, 32'h0F00_0010, 4'd2, 8'd0, INCR);
        wait_quiet("t2");
        check("t2_owner", 64'(o_owner), 64'd0);

        // T3: m1 backpressure for 3 cycles
        q_g.push_back(1'b1);
        exp_ar(32'h0F00_0100, 4'd5, 8'd0, INCR);
        exp_r(1'b1, 32'h0F00_0100, 1'b1, 4'd5);
        m1_if.rready = 1'b0;
        req(1'b1, 32'h0F00_0100, 4'd5, 8'd0, INCR);
        n = 0;
        @(negedge clk);
        while (!s_if.rvalid && n < 20) begin n++; @(negedge clk); end
        check("t3_wait_rvalid", 64'(n < 20), 64'd1);
        for (int i = 0; i < 3; i++) begin
            check("t3_s_rready", 64'(s_if.rready), 64'd0);
            check("t3_m1_rvalid", 64'(m1_if.rvalid), 64'd1);
            check("t3_m0_rvalid", 64'(m0_if.rvalid), 64'd0);
            if (i < 2) @(negedge clk);
        end
        @(posedge clk); #1;
        m1_if.rready = 1'b1;
        wait_quiet("t3");
        check("t3_owner", 64'(o_owner), 64'd1);

        // T4: tie right after an m1 transaction
`ifdef AXI_RD_ARB_ROUND_ROBIN_EN
        q_g.push_back(1'b0); q_g.push_back(1'b1);
        exp_ar(32'h1000_0040, 4'd4, 8'd2, INCR);
        exp_ar(32'h0F00_0020, 4'd6, 8'd0, FIXED);
`else
        q_g.push_back(1'b1); q_g.push_back(1'b0);
        exp_ar(32'h0F00_0020, 4'd6, 8'd0, FIXED);
        exp_ar(32'h1000_0040, 4'd4, 8'd2, INCR);
`endif
        exp_r(1'b0, 32'h1000_0040, 1'b0, 4'd4);
        exp_r(1'b0, 32'h1000_0041, 1'b0, 4'd4);
        exp_r(1'b0, 32'h1000_0042, 1'b1, 4'd4);
        exp_r(1'b1, 32'h0F00_0020, 1'b1, 4'd6);
        req(1'b0, 32'h1000_0040, 4'd4, 8'd2, INCR);
        req(1'b1, 32'h0F00_0020, 4'd6, 8'd0, FIXED);
        wait_quiet("t4");
        check("t4_perr", 64'(o_proto_err), 64'd0);

        // T5: arlen=1 but slave ends after one beat
        slv_ovr = 1;
        q_g.push_back(1'b0);
        exp_ar(32'h2000_0000, 4'd7, 8'd1, INCR);
        exp_r(1'b0, 32'h2000_0000, 1'b1, 4'd7);
        req(1'b0, 32'h2000_0000, 4'd7, 8'd1, INCR);
        wait_quiet("t5");
        slv_ovr = 0;
        check("t5_perr", 64'(o_proto_err), 64'd1);
        check("t5_busy", 64'(o_busy), 64'd0);
        q_g.push_back(1'b1);
        exp_ar(32'h0F00_0200, 4'd1, 8'd0, INCR);
        exp_r(1'b1, 32'h0F00_0200, 1'b1, 4'd1);
        req(1'b1, 32'h0F00_0200, 4'd1, 8'd0, INCR);
        wait_quiet("t5b");
        check("t5_perr_sticky", 64'(o_proto_err), 64'd1);

        // T6: async reset in DATA after beat 1 of 2 (m1 owner)
        q_g.push_back(1'b1);
        exp_ar(32'h3000_0000, 4'd9, 8'd1, INCR);
        exp_r(1'b1, 32'h3000_0000, 1'b0, 4'd9);
        req(1'b1, 32'h3000_0000, 4'd9, 8'd1, INCR);
        n = 0;
        @(negedge clk);
        while (!(m1_if.rvalid && m1_if.rready) && n < 20) begin n++; @(negedge clk); end
        check("t6_wait_beat1", 64'(n < 20), 64'd1);
        @(posedge clk); #2;
        i_reset = 1'b0;
        #1;
        check("t6_rst_busy",   64'(o_busy), 64'd0);
        check("t6_rst_owner",  64'(o_owner), 64'd0);
        check("t6_rst_perr",   64'(o_proto_err), 64'd0);
        check("t6_rst_rrdy",   64'(s_if.rready), 64'd0);
        check("t6_rst_rvalid", 64'(m1_if.rvalid), 64'd0);
        @(posedge clk); #1;
        i_reset = 1'b1;
        @(negedge clk);
        check("t6_stray", 64'({s_if.rvalid, s_if.rready, m1_if.rvalid}), 64'({1'b1, 1'b1, 1'b0}));
        @(negedge clk);
        check("t6_drain_perr", 64'(o_proto_err), 64'd1);
        check("t6_drain_busy", 64'(o_busy), 64'd0);
        wait_quiet("t6");

        // T7: normal m0 read after reset
        q_g.push_back(1'b0);
        exp_ar(32'h4000_0008, 4'd2, 8'd0, INCR);
        exp_r(1'b0, 32'h4000_0008, 1'b1, 4'd2);
        req(1'b0, 32'h4000_0008, 4'd2, 8'd0, INCR);
        wait_quiet("t7");
        check("t7_owner", 64'(o_owner), 64'd0);

        check("end_q_g",  64'(q_g.size()),  64'd0);
        check("end_q_ar", 64'(q_ar.size()), 64'd0);
        check("end_q_r0", 64'(q_r0.size()), 64'd0);
        check("end_q_r1", 64'(q_r1.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
